// File: rtl/rf_wb_if.sv
// Bundle between the decode/EXU/LSU side and the register-file writeback
// scoreboard. The pipeline side drives requests; the scoreboard drives
// stalls, grants, the RF write port and status.
//
// Writeback handshake (EXU and LSU alike): a requester raises valid with
// rd/data and holds all three stable until ready=1. The transfer happens on
// the rising clk edge where valid & ready are both high. ready is never
// high without valid.
interface rf_wb_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
);
  logic            iss_valid;
  logic            iss_rs1_en;
  logic [AW-1:0]   iss_rs1;
  logic            iss_rs2_en;
  logic [AW-1:0]   iss_rs2;
  logic            iss_rd_en;
  logic [AW-1:0]   iss_rd;
  logic            iss_stall;

  logic            exu_valid;
  logic [AW-1:0]   exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            exu_ready;

  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic [NREG-1:0] busy_vec;
  logic            wb_err;
  // Round-robin pointer: 1 = LSU was granted last, 0 = EXU.
  logic            dbg_last_grant;

  modport master (
    output iss_valid, iss_rs1_en, iss_rs1, iss_rs2_en, iss_rs2, iss_rd_en, iss_rd,
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_stall, exu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  busy_vec, wb_err, dbg_last_grant
  );

  modport slave (
    input  iss_valid, iss_rs1_en, iss_rs1, iss_rs2_en, iss_rs2, iss_rd_en, iss_rd,
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_stall, exu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output busy_vec, wb_err, dbg_last_grant
  );
endinterface

// File: rtl/rf_wb_scoreboard.sv
// Shares the single register-file write port between EXU and LSU with
// round-robin arbitration, tracks in-flight destinations in a busy vector
// and stalls issue on RAW/WAW hazards. No bypass: a register released on an
// edge becomes readable for issue in the following cycle.
module rf_wb_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic   clk,
  input  logic   reset,
  rf_wb_if.slave bus
);

  typedef enum logic {
    GNT_EXU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  grant_e          last_grant_q;
  grant_e          last_grant_d;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wb_err_q;
  logic            wb_err_d;

  logic            exu_gnt;
  logic            lsu_gnt;
  logic            any_gnt;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            stall;
  logic            acc;

  // Arbitration and write-port mux: a lone requester wins, a tie goes to
  // whoever was not granted last; nothing is granted while in reset.
  always_comb begin
    exu_gnt  = 1'b0;
    lsu_gnt  = 1'b0;
    gnt_rd   = '0;
    gnt_data = '0;
    if (!reset) begin
      exu_gnt = bus.exu_valid && (!bus.lsu_valid || last_grant_q == GNT_LSU);
      lsu_gnt = bus.lsu_valid && (!bus.exu_valid || last_grant_q == GNT_EXU);
    end
    any_gnt = exu_gnt || lsu_gnt;
    if (exu_gnt) begin
      gnt_rd   = bus.exu_rd;
      gnt_data = bus.exu_data;
    end else if (lsu_gnt) begin
      gnt_rd   = bus.lsu_rd;
      gnt_data = bus.lsu_data;
    end
  end

  // Hazard detection against the registered busy vector (x0 is never busy,
  // bit 0 is forced clear in the next-state logic).
  always_comb begin
    stall = bus.iss_valid &&
            ((bus.iss_rs1_en && busy_q[bus.iss_rs1]) ||
             (bus.iss_rs2_en && busy_q[bus.iss_rs2]) ||
             (bus.iss_rd_en  && busy_q[bus.iss_rd]));
    acc   = bus.iss_valid && !stall;
  end

  // Next state: release the granted rd, then claim the accepted rd so a new
  // producer of the same register keeps it busy; flag stray writebacks;
  // move the round-robin pointer only when someone is granted.
  always_comb begin
    busy_d       = busy_q;
    wb_err_d     = wb_err_q;
    last_grant_d = last_grant_q;
    if (any_gnt) begin
      busy_d[gnt_rd] = 1'b0;
      last_grant_d   = exu_gnt ? GNT_EXU : GNT_LSU;
      if (gnt_rd != '0 && !busy_q[gnt_rd]) begin
        wb_err_d = 1'b1;
      end
    end
    if (acc && bus.iss_rd_en && bus.iss_rd != '0) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; synchronous reset drops all in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= '0;
      wb_err_q     <= 1'b0;
      last_grant_q <= GNT_LSU;
    end else begin
      busy_q       <= busy_d;
      wb_err_q     <= wb_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output drive; x0 writebacks complete the handshake but never write.
  always_comb begin
    bus.iss_stall      = stall;
    bus.exu_ready      = exu_gnt;
    bus.lsu_ready      = lsu_gnt;
    bus.rf_wen         = any_gnt && (gnt_rd != '0);
    bus.rf_waddr       = gnt_rd;
    bus.rf_wdata       = gnt_data;
    bus.busy_vec       = busy_q;
    bus.wb_err         = wb_err_q;
    bus.dbg_last_grant = last_grant_q;
  end

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard. Expected RF writes are queued when a
// writeback request is driven and popped when rf_wen is seen.
module tb_rf_wb_scoreboard;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int EW   = AW + XLEN;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [EW-1:0] exp_q[$];

  rf_wb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) bus ();

  rf_wb_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic drive_idle();
    bus.iss_valid  = 1'b0;
    bus.iss_rs1_en = 1'b0;
    bus.iss_rs1    = '0;
    bus.iss_rs2_en = 1'b0;
    bus.iss_rs2    = '0;
    bus.iss_rd_en  = 1'b0;
    bus.iss_rd     = '0;
    bus.exu_valid  = 1'b0;
    bus.exu_rd     = '0;
    bus.exu_data   = '0;
    bus.lsu_valid  = 1'b0;
    bus.lsu_rd     = '0;
    bus.lsu_data   = '0;
  endtask

  task automatic drive_iss(input logic rs1_en, input logic [AW-1:0] rs1,
                           input logic rd_en, input logic [AW-1:0] rd);
    bus.iss_valid  = 1'b1;
    bus.iss_rs1_en = rs1_en;
    bus.iss_rs1    = rs1;
    bus.iss_rs2_en = 1'b0;
    bus.iss_rs2    = '0;
    bus.iss_rd_en  = rd_en;
    bus.iss_rd     = rd;
  endtask

  task automatic drive_exu(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = rd;
    bus.exu_data  = data;
  endtask

  task automatic drive_lsu(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = rd;
    bus.lsu_data  = data;
  endtask

  // scoreboard: every RF write must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.rf_wen === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rf_unexpected observed=%0h expected=none", {bus.rf_waddr, bus.rf_wdata});
      end
      if (exp_q.size() != 0) begin
        chk("rf_write", {bus.rf_waddr, bus.rf_wdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    drive_exu(5'd1, 64'h11);
    // no grant while reset is high
    @(negedge clk);
    chk("rst_exu_ready", bus.exu_ready, 1'b0);
    chk("rst_rf_wen", bus.rf_wen, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    bus.exu_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy_vec, 32'h0);
    chk("rst_wb_err", bus.wb_err, 1'b0);
    chk("rst_stall", bus.iss_stall, 1'b0);
    chk("rst_last_grant", bus.dbg_last_grant, 1'b1);

    // 1: issue rd=5, then EXU writes it back
    tick();
    drive_iss(1'b0, 5'd0, 1'b1, 5'd5);
    @(negedge clk);
    chk("t1_stall", bus.iss_stall, 1'b0);
    tick();
    bus.iss_valid = 1'b0;
    drive_exu(5'd5, 64'hAB);
    push_wr(5'd5, 64'hAB);
    @(negedge clk);
    chk("t1_busy_set", bus.busy_vec, 32'h20);
    chk("t1_exu_ready", bus.exu_ready, 1'b1);
    chk("t1_rf_wen", bus.rf_wen, 1'b1);
    tick();
    bus.exu_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy_clr", bus.busy_vec, 32'h0);
    chk("t1_wb_err", bus.wb_err, 1'b0);

    // 2: RAW stall on x7 until the LSU writes it back
    tick();
    drive_iss(1'b0, 5'd0, 1'b1, 5'd7);
    @(negedge clk);
    chk("t2_claim_stall", bus.iss_stall, 1'b0);
    tick();
    drive_iss(1'b1, 5'd7, 1'b0, 5'd0);
    @(negedge clk);
    chk("t2_busy", bus.busy_vec, 32'h80);
    chk("t2_stall_a", bus.iss_stall, 1'b1);
    tick();
    drive_lsu(5'd7, 64'h77);
    push_wr(5'd7, 64'h77);
    @(negedge clk);
    chk("t2_stall_b", bus.iss_stall, 1'b1);
    chk("t2_lsu_ready", bus.lsu_ready, 1'b1);
    chk("t2_exu_ready", bus.exu_ready, 1'b0);
    tick();
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    chk("t2_stall_drop", bus.iss_stall, 1'b0);
    chk("t2_busy_clr", bus.busy_vec, 32'h0);
    tick();
    bus.iss_valid = 1'b0;

    // 3: both requesters contend, grants alternate E,L,E,L
    for (int r = 10; r < 14; r++) begin
      drive_iss(1'b0, 5'd0, 1'b1, AW'(r));
      tick();
    end
    bus.iss_valid = 1'b0;
    @(negedge clk);
    chk("t3_busy", bus.busy_vec, 32'h3C00);
    tick();
    drive_exu(5'd10, 64'hA0A0);
    drive_lsu(5'd11, 64'hB1B1);
    push_wr(5'd10, 64'hA0A0);
    @(negedge clk);
    chk("t3_c0_exu", bus.exu_ready, 1'b1);
    chk("t3_c0_lsu", bus.lsu_ready, 1'b0);
    tick();
    drive_exu(5'd12, 64'hC2C2);
    push_wr(5'd11, 64'hB1B1);
    @(negedge clk);
    chk("t3_c1_exu", bus.exu_ready, 1'b0);
    chk("t3_c1_lsu", bus.lsu_ready, 1'b1);
    tick();
    drive_lsu(5'd13, 64'hD3D3);
    push_wr(5'd12, 64'hC2C2);
    @(negedge clk);
    chk("t3_c2_exu", bus.exu_ready, 1'b1);
    chk("t3_c2_lsu", bus.lsu_ready, 1'b0);
    tick();
    bus.exu_valid = 1'b0;
    push_wr(5'd13, 64'hD3D3);
    @(negedge clk);
    chk("t3_c3_exu", bus.exu_ready, 1'b0);
    chk("t3_c3_lsu", bus.lsu_ready, 1'b1);
    tick();
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    chk("t3_busy_clr", bus.busy_vec, 32'h0);
    chk("t3_last_grant", bus.dbg_last_grant, 1'b1);

    // 5: x0 is never tracked and never written
    tick();
    drive_iss(1'b1, 5'd0, 1'b1, 5'd0);
    @(negedge clk);
    chk("t5_stall", bus.iss_stall, 1'b0);
    tick();
    bus.iss_valid = 1'b0;
    drive_exu(5'd0, 64'h55);
    @(negedge clk);
    chk("t5_busy", bus.busy_vec, 32'h0);
    chk("t5_exu_ready", bus.exu_ready, 1'b1);
    chk("t5_rf_wen", bus.rf_wen, 1'b0);
    tick();
    bus.exu_valid = 1'b0;
    @(negedge clk);
    chk("t5_wb_err", bus.wb_err, 1'b0);

    // 4: writeback and new claim of x3 in the same cycle, set wins
    tick();
    drive_lsu(5'd3, 64'h33);
    push_wr(5'd3, 64'h33);
    drive_iss(1'b0, 5'd0, 1'b1, 5'd3);
    @(negedge clk);
    chk("t4_stall", bus.iss_stall, 1'b0);
    chk("t4_lsu_ready", bus.lsu_ready, 1'b1);
    tick();
    bus.lsu_valid = 1'b0;
    bus.iss_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy_set_wins", bus.busy_vec, 32'h8);
    chk("t4_wb_err", bus.wb_err, 1'b1);

    // 6: stray writeback to x9 keeps wb_err sticky; reset clears everything
    tick();
    drive_exu(5'd9, 64'h99);
    push_wr(5'd9, 64'h99);
    @(negedge clk);
    chk("t6_exu_ready", bus.exu_ready, 1'b1);
    tick();
    bus.exu_valid = 1'b0;
    @(negedge clk);
    chk("t6_wb_err", bus.wb_err, 1'b1);
    chk("t6_busy", bus.busy_vec, 32'h8);
    tick();
    drive_iss(1'b0, 5'd0, 1'b1, 5'd3);
    @(negedge clk);
    chk("t6_waw_stall", bus.iss_stall, 1'b1);
    tick();
    @(negedge clk);
    chk("t6_stall_held", bus.iss_stall, 1'b1);
    chk("t6_wb_err_sticky", bus.wb_err, 1'b1);
    reset = 1'b1;
    drive_exu(5'd3, 64'h3333);
    tick();
    @(negedge clk);
    chk("t6_rst_exu_ready", bus.exu_ready, 1'b0);
    chk("t6_rst_rf_wen", bus.rf_wen, 1'b0);
    tick();
    reset = 1'b0;
    bus.exu_valid = 1'b0;
    @(negedge clk);
    chk("t6_busy_clr", bus.busy_vec, 32'h0);
    chk("t6_wb_err_clr", bus.wb_err, 1'b0);
    chk("t6_stall_clr", bus.iss_stall, 1'b0);
    tick();
    drive_idle();
    @(negedge clk);

    chk("exp_q_empty", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
